sm16_to_fp16: RTL
=================

SM16_TO_FP16 -- requirements
Module: sm16_to_fp16

Interface
REQ-001 The block SHALL have parameter RND, default 1: 1 = round-to-nearest-even, 0 = truncate.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand present.
REQ-005 in_ready  output  1  block can accept an operand.
REQ-006 mag  input  16  unsigned magnitude from the add/sub unit.
REQ-007 neg  input  1  sign of the add/sub result, 1 = negative.
REQ-008 out_valid  output  1  out_fp holds a result.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_fp  output  16  IEEE-754 binary16 value of (-1)^neg * mag.
REQ-011 busy  output  1  state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, ROUND and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; an operand is accepted on an edge with in_valid and in_ready both 1.
REQ-014 On accept, the block SHALL capture mag into work register r, neg into sign, and load exponent e = 30.
- Next state is SHIFT if mag != 0, else DONE with out_fp = 0x0000 (positive zero, even when neg = 1).
REQ-015 In SHIFT, per cycle:
- if r[15] = 1, next state is ROUND;
- else r <= r << 1 and e <= e - 1.
REQ-016 In ROUND, the block SHALL form frac = r[14:5], lsb = r[5], guard = r[4], sticky = OR(r[3:0]).
- With RND = 1, it SHALL increment frac when guard & (sticky | lsb).
- With RND = 0, it SHALL NOT round.
REQ-017 A rounding carry out of frac SHALL set frac = 0 and e = e + 1.
- If the resulting e = 31, out_fp SHALL be sign,11111,0000000000 (infinity).
REQ-018 ROUND SHALL load out_fp = {sign, e[4:0], frac} and go to DONE.
REQ-019 out_valid SHALL be 1 only in DONE; out_fp SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-020 DONE SHALL return to IDLE on the edge with out_ready = 1; no new operand is accepted in that same cycle.
REQ-021 Latency: with accept edge = cycle 0 and lz = leading-zero count of mag, out_valid SHALL first be 1 in cycle lz+3 for nonzero mag and in cycle 1 for mag = 0.
REQ-022 Inputs mag and neg SHALL be ignored outside the accept edge.
REQ-023 in_valid while busy SHALL have no effect; the operand is not queued.

Reset
REQ-024 When rst = 1 at an edge, the next state SHALL be IDLE; rst overrides any handshake in the same cycle.
- Values after reset: out_valid = 0, out_fp = 0x0000, busy = 0, in_ready = 1, r = 0, e = 0, sign = 0.
REQ-025 Reset asserted in SHIFT, ROUND or DONE SHALL discard the operation; no out_valid pulse SHALL follow.

Structure
REQ-026 A shared package SHALL hold:
- the state enum;
- EXP_BIAS = 15, EXP_INF = 31, EXP_START = 30;
- FP16_PZERO = 16'h0000, FP16_PINF = 16'h7C00.
REQ-027 Rounding (REQ-016..REQ-017) SHALL be one combinational sub-module, fp16_round.
- Inputs: r[14:0], e, RND.
- Outputs: frac, e_out, inf.
REQ-028 The FSM, r/e/sign registers and handshake SHALL stay in sm16_to_fp16.

Verification
REQ-029 mag = 1, neg = 0, out_ready = 1 -> out_fp = 0x3C00, out_valid first in cycle 18.
REQ-030 mag = 1560, neg = 0 -> out_fp = 0x6618.
- mag = 2049 -> 0x6800 (tie rounds to even).
- mag = 2051 -> 0x6802 (tie rounds up).
REQ-031 Overflow:
- mag = 65535, neg = 0 -> 0x7C00; mag = 65535, neg = 1 -> 0xFC00.
- With RND = 0, mag = 65535 -> 0x7BFF.
REQ-032 Zero: mag = 0, neg = 1 -> out_fp = 0x0000 in cycle 1.
REQ-033 Backpressure and reset:
- Hold out_ready = 0 for 5 cycles -> out_valid and out_fp stay constant, in_ready = 0.
- Then out_ready = 1 -> in_ready = 1 the following cycle.
- rst pulsed mid-SHIFT -> IDLE, out_valid never asserted for the aborted operand.

Source files
------------

// File: rtl/sm16_to_fp16_pkg.sv
// rtl/sm16_to_fp16_pkg.sv - shared types and constants for the sign-magnitude to binary16 converter
// Holds the converter FSM state enum and the binary16 exponent/encoding constants.
package sm16_to_fp16_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_ROUND = 2'd2,
      ST_DONE  = 2'd3
   } conv_state_t;

   localparam logic [4:0]  EXP_BIAS   = 5'd15;
   localparam logic [4:0]  EXP_INF    = 5'd31;
   // A magnitude whose MSB is already at bit 15 is 2^15, i.e. biased exponent 15 + 15.
   localparam logic [4:0]  EXP_START  = 5'd30;
   localparam logic [15:0] FP16_PZERO = 16'h0000;
   localparam logic [15:0] FP16_PINF  = 16'h7C00;

endpackage

// File: rtl/fp16_round.sv
// rtl/fp16_round.sv - combinational mantissa rounding for the binary16 converter
// Ports:
//   r_low  in  15  normalised work register below its hidden one (r[14:0])
//   e      in   5  biased exponent before rounding
//   rnd    in   1  1 = round-to-nearest-even, 0 = truncate
//   frac   out 10  rounded fraction field
//   e_out  out  5  exponent after a possible rounding carry
//   inf    out  1  rounding carried into the infinity exponent
module fp16_round
   import sm16_to_fp16_pkg::*;
(
   input  logic [14:0] r_low,
   input  logic [4:0]  e,
   input  logic        rnd,
   output logic [9:0]  frac,
   output logic [4:0]  e_out,
   output logic        inf
);

   logic        lsb;
   logic        guard;
   logic        sticky;
   logic        inc;
   logic [10:0] sum;

   assign lsb    = r_low[5];
   assign guard  = r_low[4];
   assign sticky = |r_low[3:0];
   assign inc    = rnd & guard & (sticky | lsb);

   // One extra bit catches the carry out of an all-ones fraction.
   assign sum = {1'b0, r_low[14:5]} + {10'd0, inc};

   always_comb begin
      frac  = sum[9:0];
      e_out = e;
      if (sum[10]) begin
         frac  = 10'd0;
         e_out = e + 5'd1;
      end
      inf = (e_out == EXP_INF);
   end

endmodule

// File: rtl/sm16_to_fp16.sv
// rtl/sm16_to_fp16.sv - converts a 16-bit sign-magnitude result to IEEE-754 binary16
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   in_valid/in_ready operand handshake (mag, neg)
//   out_valid/out_ready result handshake (out_fp)
//   busy              converter is not idle
// Normalisation is one bit per cycle, so latency depends on the leading-zero count.
module sm16_to_fp16
   import sm16_to_fp16_pkg::*;
#(
   parameter bit RND = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] mag,
   input  logic        neg,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_fp,
   output logic        busy
);

   conv_state_t state;
   conv_state_t state_next;

   logic [15:0] r;
   logic [4:0]  e;
   logic        sign;

   logic [9:0]  rnd_frac;
   logic [4:0]  rnd_e;
   logic        rnd_inf;

   fp16_round u_round (
      .r_low (r[14:0]),
      .e     (e),
      .rnd   (RND),
      .frac  (rnd_frac),
      .e_out (rnd_e),
      .inf   (rnd_inf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               state_next = (mag != 16'd0) ? ST_SHIFT : ST_DONE;
            end
         end
         ST_SHIFT: begin
            if (r[15]) begin
               state_next = ST_ROUND;
            end
         end
         ST_ROUND: begin
            state_next = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r      <= 16'd0;
         e      <= 5'd0;
         sign   <= 1'b0;
         out_fp <= FP16_PZERO;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  r    <= mag;
                  sign <= neg;
                  e    <= EXP_START;
                  // Zero is always emitted as +0, whatever the operand sign.
                  if (mag == 16'd0) begin
                     out_fp <= FP16_PZERO;
                  end
               end
            end
            ST_SHIFT: begin
               if (!r[15]) begin
                  r <= {r[14:0], 1'b0};
                  e <= e - 5'd1;
               end
            end
            ST_ROUND: begin
               if (rnd_inf) begin
                  out_fp <= FP16_PINF | {sign, 15'd0};
               end else begin
                  out_fp <= {sign, rnd_e, rnd_frac};
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
